// File: rtl/spike_counter_bank.sv
// Per-class spike counter bank: accumulates ten spike bits over a fixed window of timesteps.
// Latency: counts valid one cycle after the final step; HOLD stalls until ready_i handshake.
// Backpressure: valid_o/count_o held stable until ready_i; define SPIKE_COUNT_SAT_EN for saturating counters.
module spike_counter_bank #(
    parameter int WIDTH_P      = 8,
    parameter int WINDOW_LEN_P = 100
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   step_i,
    input  logic [9:0]             spikes_i,
    output logic [10*WIDTH_P-1:0]  count_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   busy_o
);

    localparam int StepW = $clog2(WINDOW_LEN_P + 1);
    localparam logic [StepW-1:0] LastStep = StepW'(WINDOW_LEN_P - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_e;

    state_e                     state_q;
    logic [StepW-1:0]           step_q;
    logic [9:0][WIDTH_P-1:0]    count_q;
    logic [9:0][WIDTH_P-1:0]    count_d;
    logic                       valid_q;
    logic                       busy_q;

    always_comb begin
        count_d = count_q;
        for (int k = 0; k < 10; k++) begin
            if (spikes_i[k]) begin
`ifdef SPIKE_COUNT_SAT_EN
                if (count_q[k] != {WIDTH_P{1'b1}}) begin
                    count_d[k] = count_q[k] + WIDTH_P'(1);
                end
`else
                count_d[k] = count_q[k] + WIDTH_P'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            step_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        count_q <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (step_i) begin
                        count_q <= count_d;
                        step_q  <= step_q + StepW'(1);
                        // The final step is counted in the same edge that closes the window.
                        if (step_q == LastStep) begin
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign count_o = count_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule

// File: doc/spike_counter_bank.md
SPIKE_COUNTER_BANK -- requirements
Module: spike_counter_bank

Interface
REQ-001 The module SHALL have parameter WIDTH_P, default 8, setting the bit width of each per-class spike counter.
REQ-002 The module SHALL have parameter WINDOW_LEN_P, default 100, setting the number of timesteps per inference window; legal range 1 to 2^16-1.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port start_i, input, 1 bit: a one-cycle request to begin a new window.
REQ-006 The module SHALL have port step_i, input, 1 bit: timestep strobe; spikes_i is sampled only when step_i=1.
REQ-007 The module SHALL have port spikes_i, input, 10 bits: one spike bit per output-layer neuron, class k on bit k.
REQ-008 The module SHALL have port count_o, output, 10*WIDTH_P bits: packed spike counts, class k on [k*WIDTH_P +: WIDTH_P].
REQ-009 The module SHALL have port valid_o, output, 1 bit: count_o holds a completed window.
REQ-010 The module SHALL have port ready_i, input, 1 bit: the downstream argmax stage accepts the counts.
REQ-011 The module SHALL have port busy_o, output, 1 bit: a window is being accumulated.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COUNT and HOLD.
REQ-013 In IDLE, start_i=1 SHALL clear all ten counters and the step counter and move to COUNT on the next edge; step_i in that same cycle SHALL be ignored.
REQ-014 In COUNT, when step_i=1, counter k SHALL increment by spikes_i[k] (0 or 1) and the step counter SHALL increment by 1; when step_i=0, all counters SHALL hold.
REQ-015 The step counter SHALL be $clog2(WINDOW_LEN_P+1) bits wide.
REQ-016 On the step_i=1 cycle that completes timestep WINDOW_LEN_P, that step's spikes SHALL be counted and the FSM SHALL move to HOLD, asserting valid_o from the next cycle (latency 1 cycle after the final step).
REQ-017 In HOLD, valid_o=1 and count_o SHALL be stable, with spikes_i and step_i ignored.
REQ-018 In HOLD, valid_o=1 with ready_i=1 SHALL return the FSM to IDLE, deasserting valid_o on the next cycle.
REQ-019 valid_o SHALL never drop without a handshake.
REQ-020 start_i SHALL be ignored in COUNT and HOLD; start_i in the same cycle as a HOLD handshake SHALL also be ignored.
REQ-021 count_o SHALL retain the last window's values in IDLE until the next accepted start_i.
REQ-022 busy_o SHALL be 1 exactly in COUNT.
REQ-023 count_o, valid_o and busy_o SHALL all be registered outputs.

Reset
REQ-024 rst_ni=0 SHALL immediately set state=IDLE, all counters=0, the step counter=0, valid_o=0 and busy_o=0, regardless of clock.
REQ-025 Reset asserted mid-COUNT or mid-HOLD SHALL discard the partial window, so no valid_o follows release of reset.
REQ-026 After reset release, the block SHALL wait in IDLE for start_i.

Configuration
REQ-027 With macro SPIKE_COUNT_SAT_EN defined, each counter SHALL saturate at 2^WIDTH_P-1 and further spikes SHALL leave it unchanged.
REQ-028 Without SPIKE_COUNT_SAT_EN, counters SHALL wrap modulo 2^WIDTH_P.
REQ-029 All other behaviour SHALL be identical with or without SPIKE_COUNT_SAT_EN.

Verification
REQ-030 Basic window (WINDOW_LEN_P=4): start_i, then 4 steps with spikes_i=0x001,0x003,0x001,0x200 -> valid_o one cycle after the 4th step; count0=3, count1=1, count9=1, all other counts 0.
REQ-031 Backpressure: hold ready_i=0 for 10 cycles in HOLD -> valid_o stays 1 and count_o is unchanged; ready_i=1 -> valid_o=0 next cycle and busy_o=0.
REQ-032 Gapped steps and ignored start: WINDOW_LEN_P=4, step_i high every 3rd cycle, start_i pulsed mid-COUNT -> counting is unaffected and valid_o follows the 4th step only.
REQ-033 Overflow (WIDTH_P=4, WINDOW_LEN_P=20, spikes_i=0x3FF on every step) -> all counts=15 with SPIKE_COUNT_SAT_EN defined, and all counts=4 without it.
REQ-034 Reset mid-window: assert rst_ni=0 after 2 of 4 steps -> count_o=0, valid_o=0 and busy_o=0 immediately; after release, a new start_i gives a correct fresh window.
REQ-035 Start with step: start_i and step_i with spikes_i=0x3FF together in IDLE -> that step is not counted, and the window still requires WINDOW_LEN_P further steps.
